// File: rtl/shift_reg_sequencer.sv
// Shift-register sequencer: loads a latched word into an external shift
// register, then issues WORD_LENGTH shift strobes spaced DIV cycles apart.
// A transfer can be cancelled with abort, which emits one sync-clear strobe.
module shift_reg_sequencer #(
  parameter int WORD_LENGTH = 4,
  parameter int DIV         = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               abort,
  input  logic                               right_req,
  input  logic [WORD_LENGTH-1:0]             word_in,
  output logic                               sr_load,
  output logic                               sr_shift,
  output logic                               sr_right,
  output logic                               sr_sync_clr,
  output logic [WORD_LENGTH-1:0]             sr_parallel_in,
  output logic                               busy,
  output logic                               done,
  output logic [$clog2(WORD_LENGTH+1)-1:0]   bit_cnt
);

  localparam int BW = $clog2(WORD_LENGTH + 1);
  // Divider counts WAIT cycles 0 .. DIV-2; keep at least one bit.
  localparam int DW = (DIV > 2) ? $clog2(DIV - 1) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'((DIV >= 2) ? (DIV - 2) : 0);
  localparam logic [BW-1:0] CNT_FULL = BW'(WORD_LENGTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_CLEAR = 3'd5;

  logic [2:0]    state;
  logic [2:0]    state_nx;
  logic [DW-1:0] div_cnt;
  logic [BW-1:0] cnt_inc;

  assign cnt_inc = bit_cnt + BW'(1);

  // Next-state selection; abort is honoured in every active state but CLEAR.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_LOAD;
      S_LOAD:  state_nx = abort ? S_CLEAR : ((DIV == 1) ? S_SHIFT : S_WAIT);
      S_WAIT: begin
        if (abort)                    state_nx = S_CLEAR;
        else if (div_cnt == DIV_LAST) state_nx = S_SHIFT;
      end
      S_SHIFT: begin
        if (abort)                    state_nx = S_CLEAR;
        else if (cnt_inc == CNT_FULL) state_nx = S_DONE;
        else                          state_nx = (DIV == 1) ? S_SHIFT : S_WAIT;
      end
      S_DONE:  state_nx = abort ? S_CLEAR : S_IDLE;
      S_CLEAR: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Latched transfer parameters, shift count and WAIT divider.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_parallel_in <= '0;
      sr_right       <= 1'b0;
      bit_cnt        <= '0;
      div_cnt        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sr_parallel_in <= word_in;
            sr_right       <= right_req;
            bit_cnt        <= '0;
            div_cnt        <= '0;
          end
        end
        S_LOAD: begin
          bit_cnt <= '0;
          div_cnt <= '0;
        end
        S_WAIT:  div_cnt <= div_cnt + DW'(1);
        S_SHIFT: begin
          bit_cnt <= cnt_inc;
          div_cnt <= '0;
        end
        default: ;
      endcase
      // Entering or sitting in CLEAR overrides any count update above.
      if (state_nx == S_CLEAR || state == S_CLEAR) begin
        bit_cnt <= '0;
        div_cnt <= '0;
      end
    end
  end

  // Moore output decode.
  always_comb begin
    sr_load     = (state == S_LOAD);
    sr_shift    = (state == S_SHIFT);
    sr_sync_clr = (state == S_CLEAR);
    done        = (state == S_DONE);
    busy        = (state != S_IDLE);
  end

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Directed bench for shift_reg_sequencer: one DIV=2 instance and one DIV=1
// instance, both with WORD_LENGTH=4.
module tb_shift_reg_sequencer;

  logic       clk;
  logic       rst;
  logic       start, abort, right_req;
  logic [3:0] word_in;
  logic       sr_load, sr_shift, sr_right, sr_sync_clr, busy, done;
  logic [3:0] sr_parallel_in;
  logic [2:0] bit_cnt;

  logic       start1, abort1, right_req1;
  logic [3:0] word_in1;
  logic       sr_load1, sr_shift1, sr_right1, sr_sync_clr1, busy1, done1;
  logic [3:0] sr_parallel_in1;
  logic [2:0] bit_cnt1;

  int passed = 0;
  int total  = 0;

  shift_reg_sequencer #(.WORD_LENGTH(4), .DIV(2)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .right_req(right_req),
    .word_in(word_in), .sr_load(sr_load), .sr_shift(sr_shift), .sr_right(sr_right),
    .sr_sync_clr(sr_sync_clr), .sr_parallel_in(sr_parallel_in), .busy(busy),
    .done(done), .bit_cnt(bit_cnt)
  );

  shift_reg_sequencer #(.WORD_LENGTH(4), .DIV(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .right_req(right_req1),
    .word_in(word_in1), .sr_load(sr_load1), .sr_shift(sr_shift1), .sr_right(sr_right1),
    .sr_sync_clr(sr_sync_clr1), .sr_parallel_in(sr_parallel_in1), .busy(busy1),
    .done(done1), .bit_cnt(bit_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // {load, shift, sync_clr, done, busy}
  function automatic logic [31:0] stat0();
    return 32'({sr_load, sr_shift, sr_sync_clr, done, busy});
  endfunction

  function automatic logic [31:0] stat1();
    return 32'({sr_load1, sr_shift1, sr_sync_clr1, done1, busy1});
  endfunction

  logic [4:0] exp1 [1:11];
  logic [4:0] exp2 [1:7];
  logic [2:0] cnt2 [1:6];
  int shifts, clrs, dones, loads, rightbad;

  initial begin
    exp1 = '{5'b10001, 5'b00001, 5'b01001, 5'b00001, 5'b01001, 5'b00001,
             5'b01001, 5'b00001, 5'b01001, 5'b00011, 5'b00000};
    exp2 = '{5'b10001, 5'b01001, 5'b01001, 5'b01001, 5'b01001, 5'b00011, 5'b00000};
    cnt2 = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};

    rst = 1'b1;
    start = 0; abort = 0; right_req = 0; word_in = '0;
    start1 = 0; abort1 = 0; right_req1 = 0; word_in1 = '0;

    // Reset state
    tick();
    tick();
    chk("reset_strobes", stat0(), 32'd0);
    chk("reset_bit_cnt", 32'(bit_cnt), 32'd0);
    chk("reset_pin", 32'(sr_parallel_in), 32'd0);
    chk("reset_right", 32'(sr_right), 32'd0);
    chk("reset_strobes_div1", stat1(), 32'd0);
    rst = 1'b0;
    tick();

    // Basic transfer, DIV=2
    start = 1; word_in = 4'b1011; right_req = 0;
    tick();
    start = 0; word_in = 4'b0000;
    for (int c = 1; c <= 11; c++) begin
      chk("t1_strobes", 32'(exp1[c]), stat0());
      if (c == 10) chk("t1_bit_cnt_done", 32'(bit_cnt), 32'd4);
      if (c == 10) chk("t1_pin", 32'(sr_parallel_in), 32'hB);
      if (c == 10) chk("t1_right", 32'(sr_right), 32'd0);
      if (c < 11) tick();
    end

    // DIV=1 transfer
    start1 = 1; word_in1 = 4'b0110;
    tick();
    start1 = 0;
    for (int c = 1; c <= 7; c++) begin
      chk("t2_strobes", stat1(), 32'(exp2[c]));
      if (c <= 6) chk("t2_bit_cnt", 32'(bit_cnt1), 32'(cnt2[c]));
      if (c < 7) tick();
    end

    // Abort in the WAIT before the third shift
    start = 1; word_in = 4'b0110;
    tick();
    start = 0;
    shifts = 0; clrs = 0; dones = 0;
    for (int c = 1; c <= 10; c++) begin
      shifts += int'(sr_shift);
      clrs   += int'(sr_sync_clr);
      dones  += int'(done);
      if (c == 7) chk("t3_clear_cycle", stat0(), 32'b00101);
      abort = (c == 6);
      tick();
    end
    abort = 0;
    chk("t3_shift_count", 32'(shifts), 32'd2);
    chk("t3_clr_count", 32'(clrs), 32'd1);
    chk("t3_done_count", 32'(dones), 32'd0);
    chk("t3_idle_bit_cnt", 32'(bit_cnt), 32'd0);
    chk("t3_idle_busy", 32'(busy), 32'd0);

    // start held high, word_in changing
    start = 1; word_in = 4'b0101; right_req = 1;
    tick();
    loads = 0;
    for (int c = 1; c <= 11; c++) begin
      loads += int'(sr_load);
      if (c == 10) chk("t4_pin_hold", 32'(sr_parallel_in), 32'h5);
      if (c == 11) chk("t4_idle_busy", 32'(busy), 32'd0);
      word_in = (c == 11) ? 4'b1110 : 4'(c);
      tick();
    end
    chk("t4_single_load", 32'(loads), 32'd1);
    chk("t4_second_load", stat0(), 32'b10001);
    chk("t4_second_pin", 32'(sr_parallel_in), 32'hE);
    start = 0; abort = 1;
    tick();
    chk("t4_abort_in_load", stat0(), 32'b00101);
    abort = 0;
    tick();
    chk("t4_back_idle", stat0(), 32'd0);

    // Async reset mid-SHIFT
    start = 1; word_in = 4'b1001; right_req = 1;
    tick();
    start = 0;
    tick();
    tick();
    chk("t5_in_shift", stat0(), 32'b01001);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_strobes", stat0(), 32'd0);
    chk("t5_async_bit_cnt", 32'(bit_cnt), 32'd0);
    chk("t5_async_pin", 32'(sr_parallel_in), 32'd0);
    chk("t5_async_right", 32'(sr_right), 32'd0);
    rst = 1'b0;
    dones = 0; clrs = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      dones += int'(done);
      clrs  += int'(sr_sync_clr);
    end
    chk("t5_no_done", 32'(dones), 32'd0);
    chk("t5_no_clr", 32'(clrs), 32'd0);
    start = 1; word_in = 4'b0011; right_req = 0;
    tick();
    start = 0;
    for (int c = 1; c <= 10; c++) begin
      if (c == 1)  chk("t5_reload", stat0(), 32'b10001);
      if (c == 10) chk("t5_clean_done", stat0(), 32'b00011);
      if (c == 10) chk("t5_clean_pin", 32'(sr_parallel_in), 32'h3);
      if (c < 10) tick();
    end
    tick();

    // start and abort together in IDLE, right_req=1
    start = 1; abort = 1; right_req = 1; word_in = 4'b1100;
    tick();
    start = 0; abort = 0; right_req = 0;
    chk("t6_accepted", stat0(), 32'b10001);
    rightbad = 0; dones = 0;
    for (int c = 1; c <= 11; c++) begin
      if (busy && !sr_right) rightbad++;
      dones += int'(done);
      tick();
    end
    chk("t6_right_held", 32'(rightbad), 32'd0);
    chk("t6_done_count", 32'(dones), 32'd1);
    chk("t6_right_after", 32'(sr_right), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/shift_reg_sequencer.md
SHIFT_REG_SEQUENCER -- requirements
Module: shift_reg_sequencer

Interface
REQ-001 Parameter WORD_LENGTH, default 4, width of the sequenced shift register (legal range >= 2).
REQ-002 Parameter DIV, default 2, clock cycles per shift step (legal range >= 1).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request one transfer; sampled only in IDLE.
REQ-006 abort  input  1  cancel the transfer in progress; ignored in IDLE.
REQ-007 right_req  input  1  shift direction for the transfer (1 = right), latched with start.
REQ-008 word_in  input  WORD_LENGTH  word to load, latched with start.
REQ-009 sr_load  output  1  parallel-load strobe to the shift register.
REQ-010 sr_shift  output  1  one-step shift strobe to the shift register.
REQ-011 sr_right  output  1  direction to the shift register, the latched right_req.
REQ-012 sr_sync_clr  output  1  synchronous-clear strobe to the shift register.
REQ-013 sr_parallel_in  output  WORD_LENGTH  latched word_in driven to the register's parallel input.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse on normal completion.
REQ-016 bit_cnt  output  clog2(WORD_LENGTH+1)  number of shifts issued in the current transfer.

Function
REQ-017 The block shall be a Moore FSM with states IDLE, LOAD, WAIT, SHIFT, DONE and CLEAR; strobes shall decode from state only.
REQ-018 In IDLE with start=1, the block shall latch word_in and right_req and go to LOAD on the same edge.
REQ-019 LOAD shall last exactly 1 cycle, assert sr_load=1, clear bit_cnt to 0, and go to WAIT, or to SHIFT if DIV=1.
REQ-020 WAIT shall last DIV-1 cycles, counted by an internal divider that is cleared on entry, then go to SHIFT.
REQ-021 SHIFT shall last exactly 1 cycle with sr_shift=1, and bit_cnt shall increment on the exiting edge.
REQ-022 After SHIFT, if the incremented bit_cnt equals WORD_LENGTH the block shall go to DONE, else to WAIT (or to SHIFT if DIV=1).
REQ-023 Shift strobes shall be spaced exactly DIV cycles apart; the first shall occur DIV cycles after the LOAD cycle.
REQ-024 DONE shall last 1 cycle with done=1 and bit_cnt=WORD_LENGTH, then go to IDLE.
REQ-025 sr_load, sr_shift and sr_sync_clr shall be mutually exclusive in every cycle.
REQ-026 sr_right and sr_parallel_in shall hold their latched values from the start edge until the next accepted start.
REQ-027 start shall be ignored while busy=1; there is no queueing.
REQ-028 abort=1 in LOAD, WAIT, SHIFT or DONE shall force CLEAR on the next edge; a strobe already high in that cycle still completes.
REQ-029 CLEAR shall last 1 cycle with sr_sync_clr=1, shall reset bit_cnt to 0 and the divider, shall not pulse done, and shall then go to IDLE.
REQ-030 abort=1 in CLEAR shall have no further effect.
REQ-031 abort=1 and start=1 together in IDLE: abort is ignored and start is accepted.
REQ-032 The cycles from start sample to done pulse shall number 1 + WORD_LENGTH*DIV + 1.

Reset
REQ-033 rst=1 shall immediately force state IDLE and drive all outputs, sr_parallel_in, the latched direction, bit_cnt and the divider to 0, regardless of clk.
REQ-034 Reset asserted mid-transfer shall abandon the transfer without a done pulse or sr_sync_clr strobe.
REQ-035 After rst deasserts, the first edge with start=1 shall be accepted normally.

Verification
REQ-036 W=4, DIV=2; start at cycle 0 with word_in=4'b1011, right_req=0 -> sr_load at cycle 1, sr_shift at cycles 3, 5, 7 and 9, done at cycle 10, busy low at cycle 11, sr_parallel_in=4'b1011.
REQ-037 DIV=1, W=4; start -> sr_load at cycle 1, sr_shift at cycles 2-5, done at cycle 6, bit_cnt sequence 0,1,2,3,4.
REQ-038 abort during the WAIT before the third shift -> exactly 2 sr_shift pulses, 1 sr_sync_clr pulse, no done pulse, bit_cnt=0 in IDLE.
REQ-039 start held high throughout a transfer with word_in changing -> a single transfer, sr_parallel_in unchanged, and a new transfer accepted on the first IDLE edge.
REQ-040 Async rst pulsed between clock edges during SHIFT -> outputs go to 0 immediately, no done, and a clean transfer follows.
REQ-041 start and abort together in IDLE with right_req=1 -> transfer proceeds and sr_right=1 for its whole duration.
